// File: rtl/adc_sample_scheduler.sv
// Sample-rate tick generator and round-robin conversion sequencer for the ADC front end.
// Issues one-cycle conversion starts, waits for completion with a timeout, and delivers results over valid/ready.
module adc_sample_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int DIV_WIDTH = 16,
    parameter int DATA_W    = 12,
    parameter int TIMEOUT   = 255
) (
    input  logic                 INPUT_CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic [NUM_CH-1:0]    CH_MASK,
    input  logic [DIV_WIDTH-1:0] SAMPLE_DIV,
    input  logic                 ADC_BUSY,
    input  logic                 ADC_DONE,
    input  logic [DATA_W-1:0]    ADC_DATA,
    output logic                 CONV_START,
    output logic [CH_W-1:0]      CONV_CH,
    output logic                 SAMPLE_VALID,
    output logic [CH_W-1:0]      SAMPLE_CH,
    output logic [DATA_W-1:0]    SAMPLE_DATA,
    input  logic                 SAMPLE_READY,
    output logic                 OVERRUN,
    output logic                 TIMEOUT_ERR,
    input  logic                 ERR_CLR
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, CONVERT, DELIVER} state_t;

    state_t                 state;
    logic [DIV_WIDTH-1:0]   div_cnt, per_q, per_in;
    logic                   en_q, tick, wrap;
    logic [TO_W-1:0]        to_cnt;
    logic [CH_W-1:0]        ptr, nxt_ch;
    int                     idx;
    logic                   ovr_set, to_set;

    // The period is only reloaded at a wrap (or while stopped), so a new divider never truncates a running period.
    assign per_in = (SAMPLE_DIV == '0) ? ONE : SAMPLE_DIV;
    assign wrap   = (div_cnt == per_q - ONE);
    assign tick   = ENABLE && en_q && wrap;

    always_ff @(posedge INPUT_CLK or posedge RST) begin
        if (RST) begin
            en_q    <= 1'b0;
            div_cnt <= '0;
            per_q   <= ONE;
        end else begin
            en_q <= ENABLE;
            if (!(ENABLE && en_q) || wrap) begin
                div_cnt <= '0;
                per_q   <= per_in;
            end else begin
                div_cnt <= div_cnt + ONE;
            end
        end
    end

    // Scan downward so the nearest set bit after the pointer is the last (winning) assignment.
    always_comb begin
        nxt_ch = ptr;
        idx    = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (CH_MASK[CH_W'(idx)]) nxt_ch = CH_W'(idx);
        end
    end

    assign ovr_set = tick && ((state == WAIT_TICK && ADC_BUSY) ||
                              state == START || state == CONVERT || state == DELIVER);
    assign to_set  = (state == CONVERT) && !ADC_DONE && (to_cnt == TO_LAST);

    always_ff @(posedge INPUT_CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            ptr          <= CH_W'(NUM_CH - 1);
            to_cnt       <= '0;
            CONV_START   <= 1'b0;
            CONV_CH      <= '0;
            SAMPLE_VALID <= 1'b0;
            SAMPLE_CH    <= '0;
            SAMPLE_DATA  <= '0;
        end else begin
            CONV_START <= 1'b0;
            case (state)
                IDLE: if (ENABLE) state <= WAIT_TICK;
                WAIT_TICK: begin
                    if (!ENABLE) begin
                        state <= IDLE;
                    end else if (tick && !ADC_BUSY && CH_MASK != '0) begin
                        CONV_CH    <= nxt_ch;
                        ptr        <= nxt_ch;
                        CONV_START <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    to_cnt <= '0;
                    state  <= CONVERT;
                end
                CONVERT: begin
                    if (ADC_DONE) begin
                        SAMPLE_DATA  <= ADC_DATA;
                        SAMPLE_CH    <= CONV_CH;
                        SAMPLE_VALID <= 1'b1;
                        state        <= DELIVER;
                    end else if (to_set) begin
                        state <= ENABLE ? WAIT_TICK : IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DELIVER: begin
                    if (SAMPLE_READY) begin
                        SAMPLE_VALID <= 1'b0;
                        state        <= ENABLE ? WAIT_TICK : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as ERR_CLR wins.
    always_ff @(posedge INPUT_CLK or posedge RST) begin
        if (RST) begin
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            OVERRUN     <= ovr_set | (OVERRUN & ~ERR_CLR);
            TIMEOUT_ERR <= to_set  | (TIMEOUT_ERR & ~ERR_CLR);
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Randomized scoreboard bench for adc_sample_scheduler with an ADC front-end model and directed boundary phases.
module tb_adc_sample_scheduler;

    localparam int NUM_CH = 4, CH_W = 2, DIV_WIDTH = 16, DATA_W = 12, TOUT = 10;

    typedef struct {
        int               ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                 INPUT_CLK = 0, RST = 1, ENABLE = 0, ADC_BUSY = 0, ERR_CLR = 0;
    logic [NUM_CH-1:0]    CH_MASK = '0;
    logic [DIV_WIDTH-1:0] SAMPLE_DIV = '0;
    logic                 ADC_DONE = 0, SAMPLE_READY = 0;
    logic [DATA_W-1:0]    ADC_DATA = '0;
    logic                 CONV_START, SAMPLE_VALID, OVERRUN, TIMEOUT_ERR;
    logic [CH_W-1:0]      CONV_CH, SAMPLE_CH;
    logic [DATA_W-1:0]    SAMPLE_DATA;

    adc_sample_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_WIDTH(DIV_WIDTH),
                           .DATA_W(DATA_W), .TIMEOUT(TOUT)) dut (
        .INPUT_CLK(INPUT_CLK), .RST(RST), .ENABLE(ENABLE), .CH_MASK(CH_MASK),
        .SAMPLE_DIV(SAMPLE_DIV), .ADC_BUSY(ADC_BUSY), .ADC_DONE(ADC_DONE),
        .ADC_DATA(ADC_DATA), .CONV_START(CONV_START), .CONV_CH(CONV_CH),
        .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_CH(SAMPLE_CH), .SAMPLE_DATA(SAMPLE_DATA),
        .SAMPLE_READY(SAMPLE_READY), .OVERRUN(OVERRUN), .TIMEOUT_ERR(TIMEOUT_ERR),
        .ERR_CLR(ERR_CLR)
    );

    always #5 INPUT_CLK = ~INPUT_CLK;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, n_start = 0, n_xfer = 0;
    exp_t sb[$];
    int ch_log[$];

    // knobs driven by the stimulus process, consumed by the model process
    logic rdy_fixed = 1, rdy_rand = 0, adc_auto = 1, adc_drop = 0, rand_lat = 0;
    int   lat = 4;

    // model state, owned by the model process
    int   last_ch = NUM_CH - 1, pend_ch = 0, cd = 0;
    logic have_cur = 0, prev_start = 0;
    logic [CH_W-1:0]   cur_ch;
    logic [DATA_W-1:0] cur_data;

    always @(posedge INPUT_CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first enabled channel strictly after the last one serviced.
    function automatic int next_ch(input logic [NUM_CH-1:0] m, input int last);
        for (int k = 1; k <= NUM_CH; k++)
            if (m[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        return -1;
    endfunction

    // Ready driver, output monitor and ADC front-end model; runs mid-cycle, clear of the active edge.
    always @(negedge INPUT_CLK) begin
        exp_t e;
        int   ec;
        #1;
        SAMPLE_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        if (SAMPLE_VALID) begin
            if (!have_cur) begin
                have_cur = 1;
                cur_ch   = SAMPLE_CH;
                cur_data = SAMPLE_DATA;
                ch_log.push_back(int'(SAMPLE_CH));
                if (sb.size() == 0) chk("unexpected sample", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sample ch", SAMPLE_CH, e.ch);
                    chk("sample data", SAMPLE_DATA, e.data);
                end
            end else begin
                chk("held ch", SAMPLE_CH, cur_ch);
                chk("held data", SAMPLE_DATA, cur_data);
            end
            if (SAMPLE_READY) begin
                have_cur = 0;
                n_xfer++;
            end
        end
        ADC_DONE = 0;
        if (RST) last_ch = NUM_CH - 1;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                ADC_DONE = 1;
                ADC_DATA = DATA_W'($urandom);
                if (!adc_drop) begin
                    e.ch = pend_ch;
                    e.data = ADC_DATA;
                    sb.push_back(e);
                end
            end
        end
        if (CONV_START) begin
            n_start++;
            ec = next_ch(CH_MASK, last_ch);
            chk("conv ch", CONV_CH, ec);
            chk("start width", prev_start, 0);
            last_ch = ec;
            pend_ch = ec;
            if (adc_auto) cd = rand_lat ? int'($urandom_range(1, 6)) : lat;
        end
        prev_start = CONV_START;
    end

    task automatic go(output int k);
        @(negedge INPUT_CLK);
        ENABLE = 1;
        k = cyc;
    endtask

    task automatic wait_start(output int s, input int budget);
        int n = 0;
        do begin @(negedge INPUT_CLK); n++; end while (!CONV_START && n < budget);
        if (!CONV_START) chk("start wait expired", 0, 1);
        s = cyc;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin @(negedge INPUT_CLK); n++; end while (!SAMPLE_VALID && n < budget);
        if (!SAMPLE_VALID) chk("valid wait expired", 0, 1);
    endtask

    task automatic stop_and_drain();
        @(negedge INPUT_CLK);
        ENABLE = 0; rdy_rand = 0; rdy_fixed = 1;
        repeat (40) @(negedge INPUT_CLK);
        chk("scoreboard drained", sb.size(), 0);
        ERR_CLR = 1;
        @(negedge INPUT_CLK);
        ERR_CLR = 0;
    endtask

    initial begin
        int k, s, s2, n0, x0, vc;
        int rr_exp[6];
        rr_exp = '{0, 1, 3, 0, 1, 3};

        repeat (3) @(negedge INPUT_CLK);
        chk("reset outputs", {CONV_START, CONV_CH, SAMPLE_VALID, SAMPLE_CH, SAMPLE_DATA,
                              OVERRUN, TIMEOUT_ERR}, 0);
        RST = 0;

        // round-robin order and tick spacing
        CH_MASK = 4'b1011; SAMPLE_DIV = 20; lat = 4; rdy_fixed = 1;
        ch_log.delete();
        go(k);
        wait_start(s, 30);
        chk("first start latency", s - k, 21);
        for (int i = 1; i < 6; i++) begin
            wait_start(s2, 30);
            chk("start spacing", s2 - s, 20);
            s = s2;
        end
        repeat (8) @(negedge INPUT_CLK);
        chk("rr sample count", ch_log.size(), 6);
        for (int i = 0; i < 6 && i < ch_log.size(); i++) chk("rr order", ch_log[i], rr_exp[i]);
        chk("rr no overrun", OVERRUN, 0);
        stop_and_drain();

        // randomized masks, periods, latencies and backpressure
        for (int r = 0; r < 5; r++) begin
            CH_MASK = 4'($urandom_range(1, 15));
            SAMPLE_DIV = 16'($urandom_range(10, 25));
            rand_lat = 1; rdy_rand = 1;
            go(k);
            repeat (150) @(negedge INPUT_CLK);
            stop_and_drain();
        end
        rand_lat = 0;

        // backpressure and sticky overrun
        CH_MASK = 4'b1011; SAMPLE_DIV = 8; lat = 4; rdy_fixed = 0;
        go(k);
        wait_valid(40);
        repeat (2) @(negedge INPUT_CLK);
        chk("overrun before deliver tick", OVERRUN, 0);
        @(negedge INPUT_CLK);
        chk("overrun after deliver tick", OVERRUN, 1);
        repeat (27) @(negedge INPUT_CLK);
        chk("valid held", SAMPLE_VALID, 1);
        chk("overrun sticky", OVERRUN, 1);
        n0 = 0;
        while ((cyc - k) % 8 != 0 && n0 < 16) begin @(negedge INPUT_CLK); n0++; end
        ERR_CLR = 1;
        @(negedge INPUT_CLK);
        ERR_CLR = 0;
        chk("set beats clear", OVERRUN, 1);
        ERR_CLR = 1;
        @(negedge INPUT_CLK);
        ERR_CLR = 0;
        chk("overrun cleared", OVERRUN, 0);
        x0 = n_xfer;
        rdy_fixed = 1;
        @(negedge INPUT_CLK);
        rdy_fixed = 0;
        @(negedge INPUT_CLK);
        chk("valid drops after transfer", SAMPLE_VALID, 0);
        repeat (12) @(negedge INPUT_CLK);
        chk("single transfer", n_xfer - x0, 1);
        stop_and_drain();

        // conversion timeout
        adc_auto = 0; SAMPLE_DIV = 40;
        go(k);
        wait_start(s, 50);
        repeat (10) @(negedge INPUT_CLK);
        chk("timeout not yet", TIMEOUT_ERR, 0);
        @(negedge INPUT_CLK);
        chk("timeout flag", TIMEOUT_ERR, 1);
        chk("timeout no sample", SAMPLE_VALID, 0);
        wait_start(s2, 60);
        chk("start after timeout", s2 - s, 40);
        stop_and_drain();
        adc_auto = 1;

        // divider 0: tick every cycle, ticks in START/CONVERT dropped
        SAMPLE_DIV = 0;
        go(k);
        wait_start(s, 10);
        chk("div0 start latency", s - k, 2);
        chk("div0 overrun clear", OVERRUN, 0);
        @(negedge INPUT_CLK);
        chk("div0 overrun in start", OVERRUN, 1);
        repeat (30) @(negedge INPUT_CLK);
        stop_and_drain();

        // empty mask: ticks silently dropped
        CH_MASK = '0; SAMPLE_DIV = 5;
        n0 = n_start;
        go(k);
        repeat (40) @(negedge INPUT_CLK);
        chk("mask0 no start", n_start - n0, 0);
        chk("mask0 no overrun", OVERRUN, 0);
        stop_and_drain();

        // busy ADC at tick
        CH_MASK = 4'b1011; ADC_BUSY = 1;
        n0 = n_start;
        go(k);
        repeat (12) @(negedge INPUT_CLK);
        chk("busy no start", n_start - n0, 0);
        chk("busy overrun", OVERRUN, 1);
        ENABLE = 0;
        @(negedge INPUT_CLK);
        ADC_BUSY = 0;
        stop_and_drain();

        // enable dropped mid-conversion
        SAMPLE_DIV = 20;
        go(k);
        wait_start(s, 30);
        @(negedge INPUT_CLK);
        ENABLE = 0;
        n0 = n_start; x0 = n_xfer;
        repeat (40) @(negedge INPUT_CLK);
        chk("disable finishes sample", n_xfer - x0, 1);
        chk("disable no new start", n_start - n0, 0);
        stop_and_drain();

        // asynchronous reset mid-conversion
        SAMPLE_DIV = 0;
        go(k);
        wait_start(s, 10);
        repeat (2) @(negedge INPUT_CLK);
        chk("pre-reset overrun", OVERRUN, 1);
        #2;
        RST = 1; ENABLE = 0; adc_drop = 1;
        #1;
        chk("async reset outputs", {CONV_START, CONV_CH, SAMPLE_VALID, SAMPLE_CH, SAMPLE_DATA,
                                    OVERRUN, TIMEOUT_ERR}, 0);
        @(negedge INPUT_CLK);
        #2;
        RST = 0;
        vc = 0;
        repeat (10) begin @(negedge INPUT_CLK); if (SAMPLE_VALID) vc++; end
        chk("late done ignored", vc, 0);
        adc_drop = 0;
        SAMPLE_DIV = 20;
        go(k);
        wait_start(s, 30);
        chk("restart latency", s - k, 21);
        chk("first ch after reset", CONV_CH, 0);
        repeat (10) @(negedge INPUT_CLK);
        stop_and_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
